reg_read_stage: RTL and testbench
=================================

# reg_read_stage

Register-read stage of the execution pipe, directly downstream of the scheduler. It accepts one fired instruction per cycle (scheduler payload plus fire strobe) and reads both source operands from an internal physical register file, with same-cycle writeback bypass. It presents a registered operand packet to execute under a valid/ready handshake. A one-entry skid buffer absorbs execute back-pressure, and a ready signal tells the scheduler to hold select.

## Interface
Parameters:
- NUM_PREGS, 64, physical registers; preg 0 is hard-wired zero
- XLEN, 32, datapath width
- PREG_W, $clog2(NUM_PREGS), physical register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0), sampled on posedge clk
- fire_valid  in  1  scheduler grant valid this cycle
- sched_pkt  in  disp_packet_t  payload from scheduler; fields used: src1_preg, src2_preg, use_imm, imm; all other fields pass through untouched
- rr_ready  out  1  stage can accept a fire next cycle; scheduler suppresses grant_valid when low
- wb_valid  in  1  writeback write strobe
- wb_preg  in  PREG_W  writeback destination
- wb_data  in  XLEN  writeback value
- exec_valid  out  1  operand packet valid
- exec_ready  in  1  execute accepts packet this cycle
- exec_pkt  out  disp_packet_t  registered payload
- exec_op1  out  XLEN  source-1 value
- exec_op2  out  XLEN  source-2 value, or imm when use_imm=1
- flush  in  1  kill all in-flight packets
- rr_overflow  out  1  sticky protocol-error flag

## Operation
- PRF: NUM_PREGS x XLEN flops.
  - Written on posedge when wb_valid=1 and wb_preg!=0. Writes to preg 0 are ignored.
  - Two combinational read ports; preg 0 reads 0.
- Operand read for an incoming fire:
  - srcN = (wb_valid && wb_preg==srcN && srcN!=0) ? wb_data : PRF[srcN].
  - op2 = use_imm ? imm : src2 value.
- Storage: output register OUT (drives exec_*) and skid register SKID, each {valid, pkt, op1, op2}.
- State, encoded by the valid bits:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- Per-cycle transitions, with accept = exec_valid && exec_ready:
  - EMPTY + fire: OUT <= new → ONE.
  - ONE + accept + fire: OUT <= new, stays ONE.
  - ONE + accept, no fire: → EMPTY.
  - ONE + !accept + fire: SKID <= new → FULL.
  - FULL + accept: OUT <= SKID, SKID cleared → ONE.
  - FULL + !accept: hold.
- rr_ready = !SKID.valid, registered view of state. It is low only in FULL, so at most one fire can land after OUT stalls.
- Fire while FULL is a protocol violation. The new packet is dropped, state is unchanged, and rr_overflow sets and stays set until reset.
- Operand snoop: every cycle, any valid held entry (OUT or SKID) whose srcN preg matches wb_preg (wb_valid=1, preg!=0) replaces op1/op2 with wb_data.
  - Snoop applies only where the operand came from a register, i.e. not to op2 when use_imm=1.
  - This keeps operands from going stale under speculative wakeup.
- flush: on that posedge, OUT.valid and SKID.valid clear, and a fire in the same cycle is discarded. PRF contents are unaffected, and a wb write in the flush cycle still lands. rr_ready is 1 the following cycle.

## Timing
- Fire at cycle N with EMPTY (or ONE with accept) → exec_valid=1 at cycle N+1 with operands. Latency is 1 cycle.
- Writeback at cycle N is visible to a fire in cycle N via bypass, and via the PRF from N+1.
- Throughput is 1 packet/cycle while exec_ready=1.
- Reset values:
  - exec_valid=0, exec_pkt=0, exec_op1=0, exec_op2=0.
  - SKID cleared; rr_ready=1; rr_overflow=0.
  - All PRF entries 0.
  - Fire and wb inputs are ignored during reset.
- Reset asserted mid-stall discards OUT and SKID contents on that edge.
- exec_* are flop outputs with no combinational path from exec_ready. rr_ready is likewise a flop-derived output with no combinational path from exec_ready.
- Simultaneous flush and rst: reset wins; the resulting state is identical either way.

## Test plan
- Write preg 5 = 0xDEADBEEF; next cycle fire src1=5, src2=0, use_imm=0 → cycle+1: exec_valid=1, op1=0xDEADBEEF, op2=0.
- Same-cycle bypass: wb preg 7 = 0x1234 while firing src1=7, use_imm=1, imm=0x40 → op1=0x1234, op2=0x40. A write to preg 0 in any cycle leaves reads of preg 0 at 0.
- Back-pressure:
  - Hold exec_ready=0 and fire A then B → state FULL, rr_ready=0 from the cycle after B, exec_pkt=A.
  - Raise exec_ready → A accepted, then B presented, rr_ready=1.
  - Strict order: A, B.
- Snoop: B sits in SKID with src2=9; wb preg 9 = 0x55 during the stall → when B reaches OUT, op2=0x55.
- Overflow: in FULL, fire C → C never appears at exec_*, rr_overflow=1 and stays 1 until rst=0.
- Flush in FULL with a concurrent fire → next cycle exec_valid=0, rr_ready=1, no stale packet later. Reset mid-stall gives all outputs at their reset values.

Source files
------------

// File: rtl/reg_read_stage.sv
// Register-read stage: PRF read with writeback bypass, registered operand packet to execute
// behind a one-entry skid buffer, with operand snooping while packets are held.
package reg_read_pkg;

    localparam int unsigned PregW = 6;
    localparam int unsigned ImmW  = 32;

    typedef struct packed {
        logic [7:0]       opcode;
        logic [PregW-1:0] dst_preg;
        logic [PregW-1:0] src1_preg;
        logic [PregW-1:0] src2_preg;
        logic             use_imm;
        logic [ImmW-1:0]  imm;
    } disp_packet_t;

endpackage

module reg_read_stage
    import reg_read_pkg::*;
#(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fire_valid,
    input  disp_packet_t      sched_pkt,
    output logic              rr_ready,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_preg,
    input  logic [XLEN-1:0]   wb_data,
    output logic              exec_valid,
    input  logic              exec_ready,
    output disp_packet_t      exec_pkt,
    output logic [XLEN-1:0]   exec_op1,
    output logic [XLEN-1:0]   exec_op2,
    input  logic              flush,
    output logic              rr_overflow
);

    logic [XLEN-1:0] prf_q [NUM_PREGS];

    logic            out_valid_q, out_valid_d;
    disp_packet_t    out_pkt_q, out_pkt_d;
    logic [XLEN-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;

    logic            skid_valid_q, skid_valid_d;
    disp_packet_t    skid_pkt_q, skid_pkt_d;
    logic [XLEN-1:0] skid_op1_q, skid_op1_d, skid_op2_q, skid_op2_d;

    logic            overflow_q, overflow_d;

    logic            wb_en;
    logic            accept;
    logic [XLEN-1:0] src1_val, src2_val, new_op2;
    logic [XLEN-1:0] out_op1_s, out_op2_s, skid_op1_s, skid_op2_s;

    assign wb_en  = wb_valid && (wb_preg != '0);
    assign accept = out_valid_q && exec_ready;

    // Writeback in the same cycle takes priority over the stored PRF value.
    always_comb begin
        src1_val = '0;
        src2_val = '0;
        if (wb_en && (wb_preg == sched_pkt.src1_preg)) begin
            src1_val = wb_data;
        end else if (sched_pkt.src1_preg != '0) begin
            src1_val = prf_q[sched_pkt.src1_preg];
        end
        if (wb_en && (wb_preg == sched_pkt.src2_preg)) begin
            src2_val = wb_data;
        end else if (sched_pkt.src2_preg != '0) begin
            src2_val = prf_q[sched_pkt.src2_preg];
        end
        new_op2 = sched_pkt.use_imm ? XLEN'(sched_pkt.imm) : src2_val;
    end

    // Held entries track writebacks so a speculatively woken packet never carries a stale operand.
    always_comb begin
        out_op1_s  = out_op1_q;
        out_op2_s  = out_op2_q;
        skid_op1_s = skid_op1_q;
        skid_op2_s = skid_op2_q;
        if (out_valid_q && wb_en) begin
            if (wb_preg == out_pkt_q.src1_preg) out_op1_s = wb_data;
            if (!out_pkt_q.use_imm && (wb_preg == out_pkt_q.src2_preg)) out_op2_s = wb_data;
        end
        if (skid_valid_q && wb_en) begin
            if (wb_preg == skid_pkt_q.src1_preg) skid_op1_s = wb_data;
            if (!skid_pkt_q.use_imm && (wb_preg == skid_pkt_q.src2_preg)) skid_op2_s = wb_data;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pkt_d    = out_pkt_q;
        out_op1_d    = out_op1_s;
        out_op2_d    = out_op2_s;
        skid_valid_d = skid_valid_q;
        skid_pkt_d   = skid_pkt_q;
        skid_op1_d   = skid_op1_s;
        skid_op2_d   = skid_op2_s;
        overflow_d   = overflow_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q) begin
            if (fire_valid) begin
                out_valid_d = 1'b1;
                out_pkt_d   = sched_pkt;
                out_op1_d   = src1_val;
                out_op2_d   = new_op2;
            end
        end else if (!skid_valid_q) begin
            if (accept && fire_valid) begin
                out_pkt_d = sched_pkt;
                out_op1_d = src1_val;
                out_op2_d = new_op2;
            end else if (accept) begin
                out_valid_d = 1'b0;
            end else if (fire_valid) begin
                skid_valid_d = 1'b1;
                skid_pkt_d   = sched_pkt;
                skid_op1_d   = src1_val;
                skid_op2_d   = new_op2;
            end
        end else begin
            // Full: a fire here broke the rr_ready contract and is dropped.
            if (fire_valid) overflow_d = 1'b1;
            if (accept) begin
                out_pkt_d    = skid_pkt_q;
                out_op1_d    = skid_op1_s;
                out_op2_d    = skid_op2_s;
                skid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_PREGS); i++) prf_q[i] <= '0;
            out_valid_q  <= 1'b0;
            out_pkt_q    <= '0;
            out_op1_q    <= '0;
            out_op2_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pkt_q   <= '0;
            skid_op1_q   <= '0;
            skid_op2_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (wb_en) prf_q[wb_preg] <= wb_data;
            out_valid_q  <= out_valid_d;
            out_pkt_q    <= out_pkt_d;
            out_op1_q    <= out_op1_d;
            out_op2_q    <= out_op2_d;
            skid_valid_q <= skid_valid_d;
            skid_pkt_q   <= skid_pkt_d;
            skid_op1_q   <= skid_op1_d;
            skid_op2_q   <= skid_op2_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rr_ready    = !skid_valid_q;
    assign exec_valid  = out_valid_q;
    assign exec_pkt    = out_pkt_q;
    assign exec_op1    = out_op1_q;
    assign exec_op2    = out_op2_q;
    assign rr_overflow = overflow_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: bypass, back-pressure ordering, snoop, overflow, flush, reset.
module tb_reg_read_stage;
    import reg_read_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         fire_valid;
    disp_packet_t sched_pkt;
    logic         rr_ready;
    logic         wb_valid;
    logic [5:0]   wb_preg;
    logic [31:0]  wb_data;
    logic         exec_valid;
    logic         exec_ready;
    disp_packet_t exec_pkt;
    logic [31:0]  exec_op1;
    logic [31:0]  exec_op2;
    logic         flush;
    logic         rr_overflow;

    int checks = 0;
    int errors = 0;

    reg_read_stage dut (
        .clk         (clk),
        .rst         (rst),
        .fire_valid  (fire_valid),
        .sched_pkt   (sched_pkt),
        .rr_ready    (rr_ready),
        .wb_valid    (wb_valid),
        .wb_preg     (wb_preg),
        .wb_data     (wb_data),
        .exec_valid  (exec_valid),
        .exec_ready  (exec_ready),
        .exec_pkt    (exec_pkt),
        .exec_op1    (exec_op1),
        .exec_op2    (exec_op2),
        .flush       (flush),
        .rr_overflow (rr_overflow)
    );

    always #5 clk = ~clk;

    function automatic disp_packet_t mk(input logic [7:0] tag, input logic [5:0] s1,
                                        input logic [5:0] s2, input logic ui,
                                        input logic [31:0] imm);
        disp_packet_t p;
        p.opcode    = tag;
        p.dst_preg  = 6'd33;
        p.src1_preg = s1;
        p.src2_preg = s2;
        p.use_imm   = ui;
        p.imm       = imm;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1 time unit after an edge, so outputs checked after tick() reflect it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input disp_packet_t p);
        fire_valid = 1'b1;
        sched_pkt  = p;
    endtask

    task automatic wb(input logic [5:0] p, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_preg  = p;
        wb_data  = d;
    endtask

    task automatic idle();
        fire_valid = 1'b0;
        wb_valid   = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        disp_packet_t pa, pb, pc;
        rst = 1'b0; exec_ready = 1'b1; idle();
        sched_pkt = '0; wb_preg = '0; wb_data = '0;
        #1;
        // Fire and writeback during reset must be ignored.
        fire(mk(8'hEE, 6'd3, 6'd0, 1'b0, 32'h0));
        wb(6'd3, 32'hCAFE_F00D);
        tick(); tick();
        chk("rst_valid", 64'(exec_valid), 64'd0);
        chk("rst_pkt", 64'(exec_pkt), 64'd0);
        chk("rst_op1", 64'(exec_op1), 64'd0);
        chk("rst_op2", 64'(exec_op2), 64'd0);
        chk("rst_rr_ready", 64'(rr_ready), 64'd1);
        chk("rst_overflow", 64'(rr_overflow), 64'd0);
        rst = 1'b1; idle();

        wb(6'd5, 32'hDEAD_BEEF);
        tick(); idle();
        fire(mk(8'h01, 6'd5, 6'd0, 1'b0, 32'h0));
        tick(); idle();
        chk("prf_valid", 64'(exec_valid), 64'd1);
        chk("prf_op1", 64'(exec_op1), 64'hDEAD_BEEF);
        chk("prf_op2", 64'(exec_op2), 64'd0);
        chk("prf_pkt", 64'(exec_pkt), 64'(mk(8'h01, 6'd5, 6'd0, 1'b0, 32'h0)));

        wb(6'd7, 32'h1234);
        fire(mk(8'h02, 6'd7, 6'd0, 1'b1, 32'h40));
        tick(); idle();
        chk("byp_op1", 64'(exec_op1), 64'h1234);
        chk("byp_op2", 64'(exec_op2), 64'h40);
        chk("byp_tag", 64'(exec_pkt.opcode), 64'h02);

        wb(6'd0, 32'hFFFF_FFFF);
        fire(mk(8'h03, 6'd0, 6'd0, 1'b0, 32'h0));
        tick(); idle();
        chk("z_byp_op1", 64'(exec_op1), 64'd0);
        chk("z_byp_op2", 64'(exec_op2), 64'd0);
        fire(mk(8'h04, 6'd3, 6'd0, 1'b0, 32'h0));
        tick(); idle();
        chk("z_prf_op2", 64'(exec_op2), 64'd0);
        chk("rst_wb_ignored", 64'(exec_op1), 64'd0);
        tick();
        chk("drain_valid", 64'(exec_valid), 64'd0);

        // Back-pressure: A then B while execute stalls.
        pa = mk(8'h0A, 6'd5, 6'd7, 1'b0, 32'h0);
        pb = mk(8'h0B, 6'd7, 6'd9, 1'b0, 32'h0);
        pc = mk(8'h0C, 6'd1, 6'd2, 1'b0, 32'h0);
        exec_ready = 1'b0;
        fire(pa);
        tick(); idle();
        chk("one_rr_ready", 64'(rr_ready), 64'd1);
        fire(pb);
        tick(); idle();
        chk("full_rr_ready", 64'(rr_ready), 64'd0);
        chk("full_pkt_a", 64'(exec_pkt), 64'(pa));
        chk("full_a_op2", 64'(exec_op2), 64'h1234);
        wb(6'd9, 32'h55);
        tick(); idle();
        wb(6'd5, 32'h77);
        tick(); idle();
        chk("snoop_out_op1", 64'(exec_op1), 64'h77);
        chk("snoop_hold_tag", 64'(exec_pkt.opcode), 64'h0A);

        fire(pc);
        tick(); idle();
        chk("ovf_set", 64'(rr_overflow), 64'd1);
        chk("ovf_pkt_a", 64'(exec_pkt.opcode), 64'h0A);
        chk("ovf_rr_ready", 64'(rr_ready), 64'd0);

        exec_ready = 1'b1;
        tick();
        chk("b_pkt", 64'(exec_pkt), 64'(pb));
        chk("b_op1", 64'(exec_op1), 64'h1234);
        chk("snoop_skid_op2", 64'(exec_op2), 64'h55);
        chk("b_rr_ready", 64'(rr_ready), 64'd1);
        tick();
        chk("no_c_valid", 64'(exec_valid), 64'd0);
        chk("ovf_sticky", 64'(rr_overflow), 64'd1);

        // Flush while full with a concurrent fire and writeback.
        exec_ready = 1'b0;
        fire(mk(8'h0D, 6'd5, 6'd0, 1'b0, 32'h0));
        tick();
        fire(mk(8'h0E, 6'd5, 6'd0, 1'b0, 32'h0));
        tick();
        chk("pre_flush_rr_ready", 64'(rr_ready), 64'd0);
        fire(mk(8'h0F, 6'd5, 6'd0, 1'b0, 32'h0));
        flush = 1'b1;
        wb(6'd11, 32'hAB);
        tick(); idle();
        chk("flush_valid", 64'(exec_valid), 64'd0);
        chk("flush_rr_ready", 64'(rr_ready), 64'd1);
        tick();
        chk("flush_no_stale", 64'(exec_valid), 64'd0);
        exec_ready = 1'b1;
        fire(mk(8'h10, 6'd11, 6'd0, 1'b0, 32'h0));
        tick(); idle();
        chk("flush_wb_landed", 64'(exec_op1), 64'hAB);
        chk("post_flush_tag", 64'(exec_pkt.opcode), 64'h10);
        tick();

        // Reset in the middle of a stall.
        exec_ready = 1'b0;
        fire(mk(8'h11, 6'd5, 6'd7, 1'b0, 32'h0));
        tick();
        fire(mk(8'h12, 6'd5, 6'd7, 1'b0, 32'h0));
        tick(); idle();
        rst = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(exec_valid), 64'd0);
        chk("mid_rst_pkt", 64'(exec_pkt), 64'd0);
        chk("mid_rst_op1", 64'(exec_op1), 64'd0);
        chk("mid_rst_op2", 64'(exec_op2), 64'd0);
        chk("mid_rst_rr_ready", 64'(rr_ready), 64'd1);
        chk("mid_rst_overflow", 64'(rr_overflow), 64'd0);
        rst = 1'b1;
        exec_ready = 1'b1;
        fire(mk(8'h13, 6'd5, 6'd7, 1'b0, 32'h0));
        tick(); idle();
        chk("prf_cleared_op1", 64'(exec_op1), 64'd0);
        chk("prf_cleared_op2", 64'(exec_op2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
